mem_req_rr_mux: RTL and testbench
=================================

// Module: mem_req_rr_mux
// PURPOSE
//  Shares one banked memory port (the req/gnt/rvalid port that feeds the bank splitter) between
//  NumInp requesters. Arbitration is round-robin with a lock, so a pending request stays stable.
//  Issued transactions are tracked in an in-order index FIFO that steers each response back to its
//  requester. Outstanding transactions are capped at MaxTrans, matching the splitter's depth.
// PARAMETERS
//  NumInp    4   number of requesters, >=1
//  AddrWidth 32  byte address width
//  DataWidth 64  data width, power of two, multiple of 8
//  MaxTrans  4   max outstanding (granted, no rvalid yet) transactions, >=1
// PORTS
//  clk_i         in  1                   clock, rising edge; sole clock
//  rst_i         in  1                   reset, synchronous, active-high
//  inp_req_i     in  NumInp              requester request valid
//  inp_gnt_o     out NumInp              requester grant (one-hot or zero)
//  inp_addr_i    in  NumInp*AddrWidth    requester byte address
//  inp_wdata_i   in  NumInp*DataWidth    requester write data
//  inp_strb_i    in  NumInp*DataWidth/8  requester write strobe
//  inp_we_i      in  NumInp              requester write enable
//  inp_rvalid_o  out NumInp              response valid (one-hot or zero), reads and writes
//  inp_rdata_o   out DataWidth           response data, broadcast to all requesters
//  oup_req_o     out 1                   shared port request
//  oup_gnt_i     in  1                   shared port grant
//  oup_addr_o    out AddrWidth           muxed address
//  oup_wdata_o   out DataWidth           muxed write data
//  oup_strb_o    out DataWidth/8         muxed strobe
//  oup_we_o      out 1                   muxed write enable
//  oup_rvalid_i  in  1                   shared port response valid
//  oup_rdata_i   in  DataWidth           shared port response data
// BEHAVIOUR
//  - Reset: rr_ptr=0, lock=0, cnt=0, FIFO empty. All outputs are combinational from state/inputs.
//    With inp_req_i=0 they are 0; inp_rvalid_o=0.
//  - Selection, unlocked: the first requester with inp_req_i=1 at or after rr_ptr, scanning upward
//    with wrap. Selection is combinational, zero added latency: oup_* = inp_*[sel].
//  - oup_req_o = |inp_req_i && !full, where full = (cnt==MaxTrans). inp_gnt_o[sel] = oup_req_o && oup_gnt_i.
//  - Lock: if oup_req_o=1 and oup_gnt_i=0, set lock and store sel in lock_idx. While locked,
//    sel=lock_idx regardless of other requests. Lock clears on the handshake. Requesters never
//    drop req before gnt, so this holds the output stable.
//  - Handshake (oup_req_o && oup_gnt_i): push sel into FIFO, rr_ptr <= sel+1 (wrap to 0 at NumInp).
//  - Response: on oup_rvalid_i, pop the FIFO head h; inp_rvalid_o[h]=1 in the same cycle;
//    inp_rdata_o = oup_rdata_i. Responses are in order; there is no reordering.
//  - cnt: +1 on handshake, -1 on rvalid, unchanged when both occur in the same cycle. Width is
//    $clog2(MaxTrans+1).
//  - Full: oup_req_o is masked while cnt==MaxTrans, even when an rvalid pops in that same cycle.
//    Issue resumes the next cycle (conservative, no comb path rvalid->req).
//  - Full with a pending request: lock is not set (oup_req_o=0), so arbitration restarts when not full.
//  - rvalid while cnt==0 is a protocol error: ignored, cnt and FIFO unchanged, assertion fires.
//  - Reset mid-operation: all state is cleared in the next cycle; in-flight responses are dropped.
//    The downstream must be reset together with this block.
//  - NumInp==1: the pointer logic degenerates and the FIFO index width is 1 (constant 0).
// STRUCTURE
//  - Package mem_req_rr_mux_pkg: function idx_width(NumInp) = max(1,$clog2(NumInp)).
//  - Sub-module mem_req_idx_fifo: depth MaxTrans, width idx_width, synchronous active-high reset,
//    no fall-through, push/pop allowed in the same cycle (also when full, if a pop occurs).
//  - The top module holds the arbiter, lock register, rr_ptr, cnt and the muxes.
// TESTING
//  1 Reset: rst_i=1 for 2 cycles with all inp_req_i=1 -> inp_gnt_o=0, oup_req_o=0;
//    after release the first grant goes to requester 0.
//  2 Fairness: NumInp=4, all req held, oup_gnt_i=1, MaxTrans=4, rvalid 1 cycle after each grant
//    -> grant order 0,1,2,3,0,...
//  3 Lock: req0 and req2 asserted with oup_gnt_i=0 for 3 cycles, req0 dropped by testbench
//    violation check off, req2 kept -> oup_addr_o stays addr0 until gnt; no switch mid-wait.
//  4 Full: MaxTrans=2, two grants, no rvalid -> oup_req_o=0; on the rvalid cycle still 0;
//    next cycle 1.
//  5 Routing: grants to 3,1,3 then rvalid with rdata 0xA,0xB,0xC -> inp_rvalid_o[3]=0xA,
//    [1]=0xB, [3]=0xC.
//  6 Simultaneous: cnt=1, handshake and rvalid in the same cycle -> cnt stays 1, FIFO head advances.

Source files
------------

// File: rtl/mem_req_rr_mux_pkg.sv
// Shared definitions for the round-robin memory request multiplexer.
//   idx_width : width of a requester index, never narrower than one bit so that a
//               single-requester configuration still has a legal (constant 0) index.
package mem_req_rr_mux_pkg;

  function automatic int unsigned idx_width(input int unsigned num_inp);
    return (num_inp > 32'd1) ? unsigned'($clog2(num_inp)) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_req_idx_fifo.sv
// In-order FIFO of requester indices for transactions that have been granted but not yet
// answered. Registered output (no fall-through). Push and pop may happen in the same cycle,
// including when full, provided the pop is effective. Pops while empty are ignored.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, empties the FIFO
//   push_i   : write data_i at the tail
//   data_i   : index to store
//   pop_i    : drop the head entry
//   data_o   : head entry (valid while !empty_o)
//   empty_o  : no entries stored
module mem_req_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign pop_en  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign push_en = push_i && (!full || pop_en);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_en && !pop_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_en && !push_en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_req_rr_mux.sv
// Shares one req/gnt/rvalid memory port between NumInp requesters.
// Round-robin arbitration with a lock that holds the selection stable while the shared port
// stalls a request. Granted transactions are recorded in an in-order index FIFO that steers each
// response back to its requester; at most MaxTrans transactions are outstanding.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   inp_req_i / inp_gnt_o        : per-requester request / grant (grant one-hot or zero)
//   inp_addr_i, inp_wdata_i,
//   inp_strb_i, inp_we_i         : per-requester request payload, flat-packed
//   inp_rvalid_o / inp_rdata_o   : per-requester response valid, broadcast response data
//   oup_req_o / oup_gnt_i        : shared port handshake
//   oup_addr_o, oup_wdata_o,
//   oup_strb_o, oup_we_o         : muxed request payload (zero when nobody requests)
//   oup_rvalid_i / oup_rdata_i   : shared port response
module mem_req_rr_mux
  import mem_req_rr_mux_pkg::*;
#(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTrans  = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumInp-1:0]                 inp_req_i,
  output logic [NumInp-1:0]                 inp_gnt_o,
  input  logic [NumInp*AddrWidth-1:0]       inp_addr_i,
  input  logic [NumInp*DataWidth-1:0]       inp_wdata_i,
  input  logic [NumInp*(DataWidth/8)-1:0]   inp_strb_i,
  input  logic [NumInp-1:0]                 inp_we_i,
  output logic [NumInp-1:0]                 inp_rvalid_o,
  output logic [DataWidth-1:0]              inp_rdata_o,
  output logic                              oup_req_o,
  input  logic                              oup_gnt_i,
  output logic [AddrWidth-1:0]              oup_addr_o,
  output logic [DataWidth-1:0]              oup_wdata_o,
  output logic [DataWidth/8-1:0]            oup_strb_o,
  output logic                              oup_we_o,
  input  logic                              oup_rvalid_i,
  input  logic [DataWidth-1:0]              oup_rdata_i
);

  localparam int unsigned IdxW      = idx_width(NumInp);
  localparam int unsigned CntW      = $clog2(MaxTrans + 1);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] arb_idx;
  logic            arb_found;
  logic [IdxW:0]   cand;
  logic [IdxW-1:0] sel;
  logic            any_req;
  logic            full;
  logic            hs;
  logic            pop;
  logic [IdxW-1:0] fifo_head;
  logic            fifo_empty;

  // Round-robin: first requester at or after rr_ptr_q, scanning upward with wrap.
  always_comb begin
    arb_idx   = rr_ptr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(NumInp)) begin
        cand = cand - (IdxW + 1)'(NumInp);
      end
      if (!arb_found && inp_req_i[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign sel     = lock_q ? lock_idx_q : arb_idx;
  assign any_req = |inp_req_i;
  assign full    = (cnt_q == CntW'(MaxTrans));
  // Masking on full ignores a same-cycle rvalid to avoid a comb path rvalid -> req.
  assign oup_req_o = any_req && !full && !rst_i;
  assign hs        = oup_req_o && oup_gnt_i;
  assign pop       = oup_rvalid_i && !fifo_empty && !rst_i;

  always_comb begin
    oup_addr_o  = '0;
    oup_wdata_o = '0;
    oup_strb_o  = '0;
    oup_we_o    = 1'b0;
    if (any_req) begin
      oup_addr_o  = inp_addr_i[sel*AddrWidth +: AddrWidth];
      oup_wdata_o = inp_wdata_i[sel*DataWidth +: DataWidth];
      oup_strb_o  = inp_strb_i[sel*StrbWidth +: StrbWidth];
      oup_we_o    = inp_we_i[sel];
    end
  end

  always_comb begin
    inp_gnt_o    = '0;
    inp_rvalid_o = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      inp_gnt_o[i]    = hs && (sel == IdxW'(i));
      inp_rvalid_o[i] = pop && (fifo_head == IdxW'(i));
    end
  end

  assign inp_rdata_o = oup_rdata_i;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    if (hs) begin
      rr_ptr_d = (sel == IdxW'(NumInp - 1)) ? '0 : sel + 1'b1;
      lock_d   = 1'b0;
    end else if (oup_req_o) begin
      // Stalled by the shared port: pin the selection until the handshake.
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (hs && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !hs) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  mem_req_idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding is dropped; flag it as a downstream protocol error.
  rvalid_without_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) !(oup_rvalid_i && (cnt_q == '0))
  );

endmodule

// File: tb/tb_mem_req_rr_mux.sv
module tb_mem_req_rr_mux;

  localparam int unsigned NumInp    = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned MaxTrans  = 4;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NumInp-1:0]               req;
  logic [NumInp-1:0]               inp_gnt;
  logic [NumInp*AddrWidth-1:0]     inp_addr;
  logic [NumInp*DataWidth-1:0]     inp_wdata;
  logic [NumInp*(DataWidth/8)-1:0] inp_strb;
  logic [NumInp-1:0]               inp_we;
  logic [NumInp-1:0]               inp_rvalid;
  logic [DataWidth-1:0]            inp_rdata;
  logic                            oup_req;
  logic                            gnt;
  logic [AddrWidth-1:0]            oup_addr;
  logic [DataWidth-1:0]            oup_wdata;
  logic [DataWidth/8-1:0]          oup_strb;
  logic                            oup_we;
  logic                            rvalid;
  logic [DataWidth-1:0]            rdata;

  always #5 clk = ~clk;

  mem_req_rr_mux #(
    .NumInp    (NumInp),
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .MaxTrans  (MaxTrans)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .inp_req_i    (req),
    .inp_gnt_o    (inp_gnt),
    .inp_addr_i   (inp_addr),
    .inp_wdata_i  (inp_wdata),
    .inp_strb_i   (inp_strb),
    .inp_we_i     (inp_we),
    .inp_rvalid_o (inp_rvalid),
    .inp_rdata_o  (inp_rdata),
    .oup_req_o    (oup_req),
    .oup_gnt_i    (gnt),
    .oup_addr_o   (oup_addr),
    .oup_wdata_o  (oup_wdata),
    .oup_strb_o   (oup_strb),
    .oup_we_o     (oup_we),
    .oup_rvalid_i (rvalid),
    .oup_rdata_i  (rdata)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned seq    = 0;
  int          exp_idx_q[$];
  logic [63:0] exp_data_q[$];

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx);
    exp_idx_q.push_back(idx);
    exp_data_q.push_back(64'h5A5A_0000_0000_0000 + 64'(seq));
    seq++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    tick();
    rst = 1'b0;
    exp_idx_q.delete();
    exp_data_q.delete();
  endtask

  // Pops the scoreboard head, presents its response and checks the steering.
  task automatic respond(input string name);
    int          idx;
    logic [63:0] d;
    logic [3:0]  oh;
    if (exp_idx_q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, no response expected", name);
      return;
    end
    idx    = exp_idx_q.pop_front();
    d      = exp_data_q.pop_front();
    oh     = 4'b0001 << idx;
    rvalid = 1'b1;
    rdata  = d;
    #2;
    total++;
    if (inp_rvalid !== oh) $display("FAIL %s_rvalid: got %b expected %b", name, inp_rvalid, oh);
    else passed++;
    total++;
    if (inp_rdata !== d) $display("FAIL %s_rdata: got %h expected %h", name, inp_rdata, d);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (oup_req !== 1'b0) $display("FAIL reset_oup_req: got %b expected 0", oup_req);
      else passed++;
      total++;
      if (inp_gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", inp_gnt);
      else passed++;
    end
    rst = 1'b0;
    exp_idx_q.delete();
    exp_data_q.delete();
    #2;
    total++;
    if (inp_gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected 0001", inp_gnt);
    else passed++;
    push_exp(0);
    tick();
    req = '0; gnt = 1'b0;
    respond("reset_resp");
    tick();
    rvalid = 1'b0;
    #2;
    total++;
    if (oup_req !== 1'b0 || oup_addr !== '0 || inp_rvalid !== '0)
      $display("FAIL idle_outputs: got req=%b addr=%h rvalid=%b expected 0/0/0",
               oup_req, oup_addr, inp_rvalid);
    else passed++;
    tick();
  endtask

  task automatic test_fairness();
    int         e;
    logic [3:0] oh;
    reset_dut();
    gnt = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      req = (k == 8) ? 4'h0 : 4'hF;
      if (k > 0) respond("fair_resp");
      else #2;
      if (k < 8) begin
        e  = k % 4;
        oh = 4'b0001 << e;
        total++;
        if (inp_gnt !== oh) $display("FAIL fair_gnt_%0d: got %b expected %b", k, inp_gnt, oh);
        else passed++;
        total++;
        if (oup_addr !== addr_of(e) || oup_we !== inp_we[e])
          $display("FAIL fair_payload_%0d: got addr=%h we=%b expected addr=%h we=%b",
                   k, oup_addr, oup_we, addr_of(e), inp_we[e]);
        else passed++;
        push_exp(e);
      end else begin
        total++;
        if (inp_gnt !== 4'b0000) $display("FAIL fair_idle_gnt: got %b expected 0000", inp_gnt);
        else passed++;
      end
      tick();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_lock();
    reset_dut();
    req = 4'b0100; gnt = 1'b0;
    #2;
    total++;
    if (oup_req !== 1'b1 || oup_addr !== addr_of(2))
      $display("FAIL lock_first: got req=%b addr=%h expected 1/%h", oup_req, oup_addr, addr_of(2));
    else passed++;
    tick();
    // Requester 0 would win an unlocked arbitration from rr_ptr 0.
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++;
      if (oup_addr !== addr_of(2) || inp_gnt !== 4'b0000)
        $display("FAIL lock_hold_%0d: got addr=%h gnt=%b expected %h/0000",
                 c, oup_addr, inp_gnt, addr_of(2));
      else passed++;
      tick();
    end
    gnt = 1'b1;
    #2;
    total++;
    if (inp_gnt !== 4'b0100) $display("FAIL lock_gnt: got %b expected 0100", inp_gnt);
    else passed++;
    push_exp(2);
    tick();
    req = 4'b0001;
    respond("lock_resp2");
    total++;
    if (inp_gnt !== 4'b0001) $display("FAIL lock_next_gnt: got %b expected 0001", inp_gnt);
    else passed++;
    push_exp(0);
    tick();
    req = '0;
    respond("lock_resp0");
    tick();
    rvalid = 1'b0;
  endtask

  task automatic test_full();
    logic [3:0] oh;
    reset_dut();
    req = 4'hF; gnt = 1'b1;
    for (int k = 0; k < int'(MaxTrans); k++) begin
      oh = 4'b0001 << k;
      #2;
      total++;
      if (inp_gnt !== oh) $display("FAIL full_fill_%0d: got %b expected %b", k, inp_gnt, oh);
      else passed++;
      push_exp(k);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #2;
      total++;
      if (oup_req !== 1'b0 || inp_gnt !== 4'b0000)
        $display("FAIL full_mask_%0d: got req=%b gnt=%b expected 0/0000", c, oup_req, inp_gnt);
      else passed++;
      tick();
    end
    respond("full_resp");
    total++;
    if (oup_req !== 1'b0) $display("FAIL full_rvalid_cycle: got req=%b expected 0", oup_req);
    else passed++;
    tick();
    rvalid = 1'b0;
    #2;
    total++;
    if (oup_req !== 1'b1 || inp_gnt !== 4'b0001)
      $display("FAIL full_resume: got req=%b gnt=%b expected 1/0001", oup_req, inp_gnt);
    else passed++;
    push_exp(0);
    tick();
    req = '0;
    for (int k = 0; k < int'(MaxTrans); k++) begin
      respond("full_drain");
      tick();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_routing();
    int         order[3] = '{3, 1, 3};
    logic [3:0] oh;
    reset_dut();
    gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      oh  = 4'b0001 << order[k];
      req = oh;
      #2;
      total++;
      if (inp_gnt !== oh) $display("FAIL route_gnt_%0d: got %b expected %b", k, inp_gnt, oh);
      else passed++;
      exp_idx_q.push_back(order[k]);
      exp_data_q.push_back(64'hA + 64'(k));
      tick();
    end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      respond("route_resp");
      tick();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_simultaneous();
    int         order[3] = '{2, 3, 0};
    logic [3:0] oh;
    reset_dut();
    gnt = 1'b1; req = 4'b0001;
    #2;
    total++;
    if (inp_gnt !== 4'b0001) $display("FAIL simul_first: got %b expected 0001", inp_gnt);
    else passed++;
    push_exp(0);
    tick();
    req = 4'b0010;
    respond("simul_resp");
    total++;
    if (inp_gnt !== 4'b0010) $display("FAIL simul_gnt: got %b expected 0010", inp_gnt);
    else passed++;
    push_exp(1);
    tick();
    // Count held at 1, so exactly MaxTrans-1 further grants fit before the mask.
    rvalid = 1'b0; req = 4'hF;
    for (int k = 0; k < 3; k++) begin
      oh = 4'b0001 << order[k];
      #2;
      total++;
      if (inp_gnt !== oh) $display("FAIL simul_fill_%0d: got %b expected %b", k, inp_gnt, oh);
      else passed++;
      push_exp(order[k]);
      tick();
    end
    #2;
    total++;
    if (oup_req !== 1'b0) $display("FAIL simul_full: got req=%b expected 0", oup_req);
    else passed++;
    tick();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      respond("simul_drain");
      tick();
    end
    rvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(NumInp); i++) begin
      inp_addr[i*AddrWidth +: AddrWidth]    = addr_of(i);
      inp_wdata[i*DataWidth +: DataWidth]   = 64'hC0DE_0000_0000_0000 + 64'(i);
      inp_strb[i*(DataWidth/8) +: DataWidth/8] = 8'hF0 | 8'(i);
    end
    inp_we = 4'b0101;
    test_reset();
    test_fairness();
    test_lock();
    test_full();
    test_routing();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
